// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master bounded-burst round-robin arbiter for the single-port data RAM
module dmem_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 16,
    parameter int BURST_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(BURST_MAX) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX);

    logic          last;
    logic          run;
    logic [CW-1:0] cnt;
    logic          rd_pend;
    logic          rd_who;
    logic          gnt0;
    logic          gnt1;
    logic          sel_we;

    // Same-cycle grant: a lone requester always wins; under contention the
    // current owner keeps the RAM until its burst budget runs out.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (m0_req && m1_req) begin
                if (run && (cnt < CNT_MAX)) begin
                    gnt0 = !last;
                    gnt1 = last;
                end else begin
                    gnt0 = last;
                    gnt1 = !last;
                end
            end else begin
                gnt0 = m0_req;
                gnt1 = m1_req;
            end
        end
    end

    // RAM-side mux from the winner; the bus is held at zero when idle.
    always_comb begin
        mem_en    = gnt0 | gnt1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (gnt1) begin
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    assign sel_we = gnt1 ? m1_we : m0_we;
    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;

    // Read data returns one cycle after the grant to whichever master issued it.
    always_comb begin
        m0_rvalid = rd_pend && !rst && !rd_who;
        m1_rvalid = rd_pend && !rst && rd_who;
        m0_rdata  = m0_rvalid ? mem_rdata : '0;
        m1_rdata  = m1_rvalid ? mem_rdata : '0;
    end

    // Burst bookkeeping and outstanding-read tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            last    <= 1'b1;
            run     <= 1'b0;
            cnt     <= '0;
            rd_pend <= 1'b0;
            rd_who  <= 1'b0;
        end else if (gnt0 || gnt1) begin
            if ((gnt1 == last) && run) begin
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt  <= CW'(1);
                last <= gnt1;
            end
            run     <= 1'b1;
            rd_pend <= !sel_we;
            rd_who  <= gnt1;
        end else begin
            run     <= 1'b0;
            cnt     <= '0;
            rd_pend <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter against a grant-history reference model
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [7:0]  m0_addr, m1_addr;
    logic [15:0] m0_wdata, m1_wdata;

    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [15:0] m0_rdata, m1_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;

    logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid;
    logic [15:0] b_m0_rdata, b_m1_rdata;
    logic        b_mem_en, b_mem_we;
    logic [7:0]  b_mem_addr;
    logic [15:0] b_mem_wdata;
    logic [15:0] b_mem_rdata;
    assign b_mem_rdata = 16'h0;

    dmem_arbiter #(.AW(8), .DW(16), .BURST_MAX(4)) u_dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.AW(8), .DW(16), .BURST_MAX(1)) u_dut_b1 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    // Behavioural single-port RAM with one-cycle read latency.
    logic [15:0] ram [256];
    logic [15:0] ram_q = 16'h0;
    assign mem_rdata = ram_q;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        ram_q <= ram[mem_addr];
        end
    end

    // Reference model state: grant history per instance (0/1 = winner, 2 = idle cycle).
    int          hist_a[$];
    int          hist_b[$];
    int          mrw_a, mrw_b;
    logic [15:0] refmem [256];
    bit          pend;
    int          pend_who;
    logic [15:0] pend_data;
    int          wa, wb;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic int decide(input int hq[$], input int mrw, input int bmax,
                                  input bit r0, input bit r1);
        int streak;
        int lastw;
        if (!r0 && !r1) return 2;
        if (r0 && !r1)  return 0;
        if (r1 && !r0)  return 1;
        if (hq.size() > 0 && hq[hq.size()-1] != 2) begin
            lastw  = hq[hq.size()-1];
            streak = 0;
            for (int i = hq.size() - 1; i >= 0; i--) begin
                if (hq[i] != lastw) break;
                streak++;
            end
            return (streak < bmax) ? lastw : 1 - lastw;
        end
        return 1 - mrw;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rs,
                        input bit q0, input bit w0, input logic [7:0] a0, input logic [15:0] d0,
                        input bit q1, input bit w1, input logic [7:0] a1, input logic [15:0] d1);
        bit          ewe, rv0, rv1;
        logic [7:0]  ead;
        logic [15:0] ewd;
        @(negedge clk);
        rst = rs;
        m0_req = q0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = q1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
        #1;
        wa  = rs ? 2 : decide(hist_a, mrw_a, 4, q0, q1);
        wb  = rs ? 2 : decide(hist_b, mrw_b, 1, q0, q1);
        ewe = (wa == 0) ? w0 : (wa == 1) ? w1 : 1'b0;
        ead = (wa == 0) ? a0 : (wa == 1) ? a1 : 8'h0;
        ewd = (wa == 0) ? d0 : (wa == 1) ? d1 : 16'h0;
        rv0 = pend && !rs && pend_who == 0;
        rv1 = pend && !rs && pend_who == 1;
        chk("m0_gnt",    32'(m0_gnt),    32'(wa == 0));
        chk("m1_gnt",    32'(m1_gnt),    32'(wa == 1));
        chk("mem_en",    32'(mem_en),    32'(wa != 2));
        chk("mem_we",    32'(mem_we),    32'(ewe));
        chk("mem_addr",  32'(mem_addr),  32'(ead));
        chk("mem_wdata", 32'(mem_wdata), 32'(ewd));
        chk("m0_rvalid", 32'(m0_rvalid), 32'(rv0));
        chk("m1_rvalid", 32'(m1_rvalid), 32'(rv1));
        chk("m0_rdata",  32'(m0_rdata),  rv0 ? 32'(pend_data) : 32'h0);
        chk("m1_rdata",  32'(m1_rdata),  rv1 ? 32'(pend_data) : 32'h0);
        chk("b1_m0_gnt", 32'(b_m0_gnt),  32'(wb == 0));
        chk("b1_m1_gnt", 32'(b_m1_gnt),  32'(wb == 1));
        chk("b1_mem_en", 32'(b_mem_en),  32'(wb != 2));
        if (rs) begin
            hist_a.delete(); hist_b.delete();
            mrw_a = 1; mrw_b = 1;
            pend  = 1'b0;
        end else begin
            hist_a.push_back(wa); hist_b.push_back(wb);
            if (hist_a.size() > 8) void'(hist_a.pop_front());
            if (hist_b.size() > 8) void'(hist_b.pop_front());
            if (wa != 2) mrw_a = wa;
            if (wb != 2) mrw_b = wb;
            pend     = (wa != 2) && !ewe;
            pend_who = wa;
            if (pend) pend_data = refmem[ead];
            if (wa != 2 && ewe) refmem[ead] = ewd;
        end
    endtask

    bit          h0, h1, rr;
    bit          hw0, hw1;
    logic [7:0]  ha0, ha1;
    logic [15:0] hd0, hd1;

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]    = 16'($urandom);
            refmem[i] = ram[i];
        end
        ram[8'h05] = 16'hBEEF; refmem[8'h05] = 16'hBEEF;
        ram[8'h01] = 16'h1111; refmem[8'h01] = 16'h1111;
        ram[8'h02] = 16'h2222; refmem[8'h02] = 16'h2222;
        pend = 1'b0; pend_who = 0; pend_data = 16'h0;
        mrw_a = 1; mrw_b = 1;
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;

        // reset with both requesting: grants forced low
        step(1, 1, 1, 8'h33, 16'h1234, 1, 0, 8'h44, 16'h5678);
        step(1, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);

        // m0 reads 0x05 alone, data returns next cycle
        step(0, 1, 0, 8'h05, 16'h0000, 0, 0, 8'h00, 16'h0000);
        step(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);

        // m1 writes 0x12, m0 reads it back
        step(0, 0, 0, 8'h00, 16'h0000, 1, 1, 8'h12, 16'hA5A5);
        step(0, 1, 0, 8'h12, 16'h0000, 0, 0, 8'h00, 16'h0000);
        step(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);

        // continuous contention from reset
        step(1, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);
        for (int i = 0; i < 20; i++)
            step(0, 1, 0, 8'(i), 16'h0, 1, 0, 8'(i + 64), 16'h0);

        // interleaved reads with no idle cycle between them
        step(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);
        step(0, 1, 0, 8'h01, 16'h0000, 0, 0, 8'h00, 16'h0000);
        step(0, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h02, 16'h0000);
        step(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);

        // reset right after an m1 read grant, then contention
        step(0, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h02, 16'h0000);
        step(1, 1, 1, 8'h07, 16'hFFFF, 1, 1, 8'h08, 16'hFFFF);
        step(0, 1, 0, 8'h07, 16'h0000, 1, 0, 8'h08, 16'h0000);
        step(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);

        // lone requester is never throttled
        for (int i = 0; i < 5; i++)
            step(0, 1, 1, 8'(i + 100), 16'(i * 3 + 7), 0, 0, 8'h00, 16'h0000);

        // randomized traffic: masters hold a request until granted
        h0 = 0; h1 = 0;
        for (int i = 0; i < 400; i++) begin
            rr = ($urandom_range(0, 63) == 0);
            if (!h0 && $urandom_range(0, 2) != 0) begin
                h0 = 1; hw0 = 1'($urandom); ha0 = 8'($urandom_range(0, 15)); hd0 = 16'($urandom);
            end
            if (!h1 && $urandom_range(0, 2) != 0) begin
                h1 = 1; hw1 = 1'($urandom); ha1 = 8'($urandom_range(0, 15)); hd1 = 16'($urandom);
            end
            step(rr, h0, hw0, h0 ? ha0 : 8'h0, h0 ? hd0 : 16'h0,
                     h1, hw1, h1 ? ha1 : 8'h0, h1 ? hd1 : 16'h0);
            if (rr || wa == 0) h0 = 0;
            if (rr || wa == 1) h1 = 0;
        end
        step(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory between two requesters: the CPU data path (port 0) and the program/data loader or debug port (port 1).
- Sits between `system_cpu_master` and the data RAM.
- Arbitrates with a bounded-burst round-robin policy and muxes address, write data and enable to the RAM.
- Routes one-cycle-latency read data back to the master that issued the read.

Parameters:
- AW, 8, address width in words.
- DW, 16, data width.
- BURST_MAX, 4, max consecutive grants to one master while the other is requesting (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  1  CPU access request; held until granted.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  AW  word address.
- m0_wdata  in  DW  write data.
- m0_gnt  out  1  access accepted this cycle.
- m0_rvalid  out  1  read data valid (cycle after grant).
- m0_rdata  out  DW  read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as port 0, for the loader.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, valid the cycle after a read strobe.

Behaviour:
- State registers:
  - last (1b): most recently granted master. Reset 1, so m0 wins the first contention.
  - run (1b): the previous cycle was a grant.
  - cnt (clog2(BURST_MAX)+1 bits): consecutive grants to `last`. Reset 0.
  - rd_pend (1b), rd_who (1b): outstanding read and its owner. Reset 0.
- Grant decision is combinational, in the same cycle as req:
  - Only mX_req high → grant X.
  - Both high, run=1, cnt<BURST_MAX → grant last (continue burst).
  - Both high, otherwise → grant ~last.
  - Neither high → no grant.
- Exactly one of m0_gnt/m1_gnt high at most. Both are forced 0 while rst=1.
- mem_en = m0_gnt|m1_gnt.
- mem_we/addr/wdata are muxed from the winner; they are 0 when mem_en=0.
- Update on grant to X:
  - If X==last and run=1: cnt = cnt+1, saturating at BURST_MAX.
  - Else: cnt=1, last=X.
  - run=1.
- Update on no grant: run=0, cnt=0. last is unchanged.
- Read return:
  - A grant with we=0 sets rd_pend=1, rd_who=X.
  - Next cycle: m{rd_who}_rvalid=1 (combinational from rd_pend), m{rd_who}_rdata=mem_rdata.
  - The other master's rdata = 0.
  - Back-to-back reads (either master) are fully pipelined, one per cycle, with no bubble.
- Writes complete at the grant edge and produce no rvalid.
- A master may change addr/we/wdata only after seeing gnt. A request dropped before grant is simply not serviced.
- Reset mid-operation: rst suppresses the pending rvalid in the same cycle and clears all state. Outputs during rst: gnt=0, rvalid=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- BURST_MAX=1 degenerates to strict alternation under contention.
- A single requester is never throttled: cnt saturates, and the grant persists every cycle.

Test Plan:
- Reset, then m0 reads addr 0x05 alone (RAM preloaded 0x05=0xBEEF): m0_gnt=1 same cycle, mem_addr=0x05, mem_we=0; next cycle m0_rvalid=1, m0_rdata=0xBEEF, m1_rvalid=0.
- m1 writes 0x12←0xA5A5, then m0 reads 0x12 the following cycle: mem_we=1 first cycle; m0_rdata=0xA5A5 one cycle after its grant.
- Both request continuously from reset, BURST_MAX=4:
  - Cycle 1 grants m0 (last reset 1).
  - Then m0 holds for 4 grants total, m1 gets 4, and so on; each mX_gnt run is ≤4.
- Interleaved reads: m0 reads 0x01, m1 reads 0x02 on consecutive cycles (RAM 0x01=0x1111, 0x02=0x2222): m0_rvalid/0x1111, then m1_rvalid/0x2222 on consecutive cycles, with no mis-routing.
- Reset mid-operation: assert rst in the cycle after an m1 read grant. Required: m1_rvalid=0, all outputs 0, and after release both requesting → m0 granted first.
- BURST_MAX=1 with both requesting for 6 cycles: grants alternate m0,m1,m0,m1,m0,m1. m0 alone for 5 cycles: gnt high all 5.
